// File: rtl/multicycle_core.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB sequencing around one shared ALU,
// with req/ack handshakes to external instruction and data memories.
`timescale 1ns/1ps
module multicycle_core #(
    parameter int unsigned IAW      = 5,
    parameter int unsigned DAW      = 5,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter bit          R0_ZERO  = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic           imem_req_o,
    output logic [IAW-1:0] imem_addr_o,
    input  logic           imem_ack_i,
    input  logic [31:0]    imem_rdata_i,
    output logic           dmem_req_o,
    output logic           dmem_we_o,
    output logic [DAW-1:0] dmem_addr_o,
    output logic [31:0]    dmem_wdata_o,
    input  logic           dmem_ack_i,
    input  logic [31:0]    dmem_rdata_i,
    output logic [31:0]    pc_out_o,
    output logic [2:0]     status_out_o,
    output logic           halted_o
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [5:0] OP_R      = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_NANDI  = 6'h1C;
    localparam logic [5:0] OP_BLEZAL = 6'h1D;
    localparam logic [5:0] OP_BALV   = 6'h1E;
    localparam logic [5:0] OP_JMXOR  = 6'h1F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_BRV = 6'h14;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    function automatic logic op_defined(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_R:    return fn inside {FN_BRV, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
            OP_J, OP_BEQ, OP_ADDI, OP_NANDI, OP_BLEZAL,
            OP_BALV, OP_JMXOR, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    state_t         state_q, state_d;
    logic           idle_q, idle_d;
    logic [31:0]    pc_q, pc_d;
    logic [2:0]     status_q, status_d;
    logic [31:0]    regs_q [32];
    logic [31:0]    ir_q, ir_d;
    logic [31:0]    pc4_q, pc4_d;
    logic [31:0]    a_q, a_d;
    logic [31:0]    b_q, b_d;
    logic [DAW-1:0] addr_q, addr_d;
    logic [31:0]    mdr_q, mdr_d;

    logic           rf_we;
    logic [4:0]     rf_waddr;
    logic [31:0]    rf_wdata;

    logic [5:0]        op, fn;
    logic [4:0]        rs, rt, rd;
    logic signed [31:0] simm, a_s, b_s;
    logic [31:0]       br_tgt, jmp_tgt;
    logic [31:0]       alu_res;
    logic              alu_v;

    assign op      = ir_q[31:26];
    assign rs      = ir_q[25:21];
    assign rt      = ir_q[20:16];
    assign rd      = ir_q[15:11];
    assign fn      = ir_q[5:0];
    assign simm    = {{16{ir_q[15]}}, ir_q[15:0]};
    assign a_s     = a_q;
    assign b_s     = b_q;
    assign br_tgt  = pc4_q + {simm[29:0], 2'b00};
    assign jmp_tgt = {pc4_q[31:28], ir_q[25:0], 2'b00};

    assign imem_req_o   = (state_q == S_FETCH) && !idle_q;
    assign imem_addr_o  = pc_q[IAW-1:0];
    assign dmem_req_o   = (state_q == S_MEM);
    assign dmem_we_o    = (state_q == S_MEM) && (op == OP_SW);
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = b_q;
    assign pc_out_o     = pc_q;
    assign status_out_o = status_q;
    assign halted_o     = (state_q == S_HALT);

    // Shared ALU for R-type ops; V is meaningful only for add/sub
    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        case (fn)
            FN_ADD: begin
                alu_res = a_q + b_q;
                alu_v   = (a_q[31] == b_q[31]) && (alu_res[31] != a_q[31]);
            end
            FN_SUB: begin
                alu_res = a_q - b_q;
                alu_v   = (a_q[31] != b_q[31]) && (alu_res[31] != a_q[31]);
            end
            FN_AND:  alu_res = a_q & b_q;
            FN_OR:   alu_res = a_q | b_q;
            FN_SLT:  alu_res = {31'd0, (a_s < b_s)};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idle_d   = idle_q;
        pc_d     = pc_q;
        status_d = status_q;
        ir_d     = ir_q;
        pc4_d    = pc4_q;
        a_d      = a_q;
        b_d      = b_q;
        addr_d   = addr_q;
        mdr_d    = mdr_q;
        rf_we    = 1'b0;
        rf_waddr = rt;
        rf_wdata = '0;
        case (state_q)
            S_FETCH: begin
                // The first FETCH cycle after every instruction keeps req low
                if (idle_q) begin
                    idle_d = 1'b0;
                end else if (imem_ack_i) begin
                    ir_d    = imem_rdata_i;
                    pc4_d   = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = regs_q[rs];
                b_d     = regs_q[rt];
                state_d = op_defined(op, fn) ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                idle_d  = 1'b1;
                pc_d    = pc4_q;
                case (op)
                    OP_R: begin
                        if (fn == FN_BRV) begin
                            pc_d = status_q[2] ? a_q : pc4_q;
                        end else begin
                            rf_we    = 1'b1;
                            rf_waddr = rd;
                            rf_wdata = alu_res;
                            status_d = {alu_res[31], (alu_res == 32'd0), alu_v};
                        end
                    end
                    OP_ADDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = a_q + simm;
                    end
                    OP_NANDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = ~(a_q & {16'h0000, ir_q[15:0]});
                    end
                    OP_BEQ: pc_d = (a_q == b_q) ? br_tgt : pc4_q;
                    OP_J:   pc_d = jmp_tgt;
                    OP_BLEZAL: begin
                        if (a_s <= 0) begin
                            rf_we    = 1'b1;
                            rf_waddr = 5'd31;
                            rf_wdata = pc4_q;
                            pc_d     = br_tgt;
                        end
                    end
                    OP_BALV: begin
                        if (status_q[0]) begin
                            rf_we    = 1'b1;
                            rf_waddr = 5'd31;
                            rf_wdata = pc4_q;
                            pc_d     = jmp_tgt;
                        end
                    end
                    OP_LW, OP_SW: begin
                        addr_d  = DAW'(a_q + simm);
                        pc_d    = pc_q;
                        idle_d  = idle_q;
                        state_d = S_MEM;
                    end
                    OP_JMXOR: begin
                        addr_d  = DAW'(a_q ^ b_q);
                        pc_d    = pc_q;
                        idle_d  = idle_q;
                        state_d = S_MEM;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (dmem_ack_i) begin
                    if (op == OP_SW) begin
                        pc_d    = pc4_q;
                        idle_d  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = dmem_rdata_i;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                idle_d  = 1'b1;
                state_d = S_FETCH;
                if (op == OP_JMXOR) begin
                    rf_waddr = 5'd31;
                    rf_wdata = pc4_q;
                    pc_d     = mdr_q << 2;
                end else begin
                    rf_wdata = mdr_q;
                    pc_d     = pc4_q;
                end
            end
            S_HALT:  ;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            idle_q   <= 1'b1;
            pc_q     <= RESET_PC;
            status_q <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            pc_q     <= pc_d;
            status_q <= status_d;
            if (rf_we && !(R0_ZERO && (rf_waddr == 5'd0))) regs_q[rf_waddr] <= rf_wdata;
        end
    end

    // Datapath latches are always written before use, so they carry no reset
    always_ff @(posedge clk) begin
        ir_q   <= ir_d;
        pc4_q  <= pc4_d;
        a_q    <= a_d;
        b_q    <= b_d;
        addr_q <= addr_d;
        mdr_q  <= mdr_d;
    end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed programs for multicycle_core with handshake memory models and a store scoreboard.
`timescale 1ns/1ps
module tb_multicycle_core;

    localparam int unsigned IAW = 8;
    localparam int unsigned DAW = 6;
    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           imem_req_o;
    logic [IAW-1:0] imem_addr_o;
    logic           imem_ack_i = 1'b0;
    logic [31:0]    imem_rdata_i = '0;
    logic           dmem_req_o;
    logic           dmem_we_o;
    logic [DAW-1:0] dmem_addr_o;
    logic [31:0]    dmem_wdata_o;
    logic           dmem_ack_i = 1'b0;
    logic [31:0]    dmem_rdata_i = '0;
    logic [31:0]    pc_out_o;
    logic [2:0]     status_out_o;
    logic           halted_o;

    logic [31:0] imem [64];
    logic [31:0] dmem [16];

    int tests = 0;
    int fails = 0;

    typedef struct {logic [31:0] a; logic [31:0] d;} st_t;
    st_t sbq[$];

    int i_maxw = 0, d_maxw = 0;
    bit i_hold = 0, d_hold = 0, i_stall = 0;
    int d_count = 0;

    multicycle_core #(.IAW(IAW), .DAW(DAW), .RESET_PC(32'h0), .R0_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .pc_out_o(pc_out_o), .status_out_o(status_out_o), .halted_o(halted_o)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    // Instruction memory responder: wait states chosen when a request first appears
    logic [IAW-1:0] i_addr_h;
    bit i_busy = 0, i_prev = 0, i_done;
    int i_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (i_prev && rst_n) check("imem_req_gap", imem_req_o, 0);
        i_done = 0;
        if (rst_n && imem_req_o && !i_stall) begin
            if (!i_busy) begin
                i_busy = 1;
                i_addr_h = imem_addr_o;
                i_cnt = (i_maxw == 0) ? 0 : $urandom_range(0, i_maxw);
            end else begin
                check("imem_addr_stable", imem_addr_o, i_addr_h);
            end
            if (i_cnt == 0) begin
                imem_ack_i = 1;
                imem_rdata_i = imem[imem_addr_o[7:2]];
                i_busy = 0;
                i_done = 1;
            end else begin
                imem_ack_i = 0;
                i_cnt--;
            end
        end else begin
            imem_ack_i = i_hold && !i_stall && rst_n;
            i_busy = 0;
        end
        i_prev = i_done;
    end

    // Data memory responder: performs the access and checks stores against the scoreboard
    logic [DAW+32:0] d_h;
    bit d_busy = 0, d_prev = 0, d_done;
    int d_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (d_prev && rst_n) check("dmem_req_gap", dmem_req_o, 0);
        d_done = 0;
        if (rst_n && dmem_req_o) begin
            if (!d_busy) begin
                d_busy = 1;
                d_h = {dmem_we_o, dmem_addr_o, dmem_wdata_o};
                d_cnt = (d_maxw == 0) ? 0 : $urandom_range(0, d_maxw);
            end else begin
                check("dmem_ctl_stable", 32'({dmem_we_o, dmem_addr_o} ^ d_h[DAW+32:32]), 0);
                check("dmem_wdata_stable", dmem_wdata_o, d_h[31:0]);
            end
            if (d_cnt == 0) begin
                dmem_ack_i = 1;
                d_busy = 0;
                d_done = 1;
                d_count++;
                if (dmem_we_o) begin
                    dmem[dmem_addr_o[5:2]] = dmem_wdata_o;
                    tests++;
                    assert (sbq.size() != 0) else begin
                        fails++;
                        $error("FAIL sb_extra_store: observed store %h to %h expected none",
                               dmem_wdata_o, dmem_addr_o);
                    end
                    if (sbq.size() != 0) begin
                        st_t e;
                        e = sbq.pop_front();
                        check("store_addr", 32'(dmem_addr_o), e.a);
                        check("store_data", dmem_wdata_o, e.d);
                    end
                end else begin
                    dmem_rdata_i = dmem[dmem_addr_o[5:2]];
                end
            end else begin
                dmem_ack_i = 0;
                d_cnt--;
            end
        end else begin
            dmem_ack_i = d_hold && rst_n;
            d_busy = 0;
        end
        d_prev = d_done;
    end

    task automatic clear_mem();
        for (int k = 0; k < 64; k++) imem[k] = HALT_W;
        for (int k = 0; k < 16; k++) dmem[k] = '0;
        sbq.delete();
        d_count = 0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        st_t e;
        e.a = a;
        e.d = d;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic run_to_halt(input int budget, output int cyc);
        cyc = 0;
        while (halted_o !== 1'b1 && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("halt_reached", halted_o, 1);
    endtask

    initial begin
        int cyc;
        int w;
        int reqs;
        logic [31:0] v;

        // Test 1: reset while a fetch is stalled
        clear_mem();
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
        i_stall = 1;
        do_reset();
        #1;
        check("t1_rst_pc", pc_out_o, 32'h0);
        check("t1_rst_status", 32'(status_out_o), 0);
        check("t1_rst_halted", halted_o, 0);
        check("t1_rst_ireq", imem_req_o, 0);
        check("t1_rst_dreq", dmem_req_o, 0);
        check("t1_rst_dwe", dmem_we_o, 0);
        repeat (2) begin @(posedge clk); #1; end
        check("t1_fetch_req", imem_req_o, 1);
        check("t1_fetch_addr", 32'(imem_addr_o), 0);
        repeat (3) begin @(posedge clk); #1; end
        check("t1_stall_req_held", imem_req_o, 1);
        check("t1_stall_pc_held", pc_out_o, 32'h0);
        #3;
        rst_n = 0;
        #1;
        check("t1_req_drop_async", imem_req_o, 0);
        @(negedge clk);
        i_stall = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
        check("t1_pc_after_rst", pc_out_o, 32'h0);
        w = 0;
        while (!imem_req_o && w < 5) begin @(posedge clk); #1; w++; end
        check("t1_refetch_req", imem_req_o, 1);
        check("t1_refetch_addr", 32'(imem_addr_o), 0);
        run_to_halt(200, cyc);
        check("t1_halt_pc", pc_out_o, 32'h4);

        // Test 2: add overflow sets {N,Z,V}=101, balv taken; zero-wait memories holding ack
        clear_mem();
        i_hold = 1; d_hold = 1;
        dmem[8] = 32'h7FFF_FFFF;
        dmem[9] = 32'h1;
        imem[0] = enc_i(6'h23, 5'd0, 5'd1, 16'h20);
        imem[1] = enc_i(6'h23, 5'd0, 5'd2, 16'h24);
        imem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        imem[3] = enc_j(6'h1E, 26'd6);
        imem[6] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0);
        imem[7] = enc_i(6'h2B, 5'd0, 5'd31, 16'h4);
        push(32'h0, 32'h8000_0000);
        push(32'h4, 32'h10);
        do_reset();
        run_to_halt(500, cyc);
        check("t2_cycles", cyc, 33);
        check("t2_status", 32'(status_out_o), 32'h5);
        check("t2_halt_pc", pc_out_o, 32'h20);
        check("t2_sb_left", sbq.size(), 0);
        i_hold = 0; d_hold = 0;

        // Test 3: brv falls through with N=0, jumps to rs with N=1
        clear_mem();
        dmem[9] = 32'h1;
        dmem[10] = 32'h28;
        imem[0] = enc_i(6'h23, 5'd0, 5'd2, 16'h24);
        imem[1] = enc_i(6'h23, 5'd0, 5'd5, 16'h28);
        imem[2] = enc_r(5'd2, 5'd2, 5'd3, 6'h22);
        imem[3] = enc_r(5'd5, 5'd0, 5'd0, 6'h14);
        imem[4] = enc_r(5'd0, 5'd2, 5'd4, 6'h2A);
        imem[5] = enc_r(5'd0, 5'd2, 5'd6, 6'h22);
        imem[6] = enc_r(5'd5, 5'd0, 5'd0, 6'h14);
        imem[10] = enc_i(6'h2B, 5'd0, 5'd4, 16'h0);
        imem[11] = enc_i(6'h2B, 5'd0, 5'd6, 16'h4);
        imem[12] = enc_i(6'h2B, 5'd0, 5'd3, 16'h8);
        push(32'h0, 32'h1);
        push(32'h4, 32'hFFFF_FFFF);
        push(32'h8, 32'h0);
        do_reset();
        run_to_halt(800, cyc);
        check("t3_status", 32'(status_out_o), 32'h4);
        check("t3_halt_pc", pc_out_o, 32'h34);
        check("t3_sb_left", sbq.size(), 0);

        // Test 4: store then load back under random wait states
        clear_mem();
        i_maxw = 4; d_maxw = 4;
        v = $urandom | 32'h1;
        dmem[9] = v;
        imem[0] = enc_i(6'h23, 5'd0, 5'd2, 16'h24);
        imem[1] = enc_i(6'h2B, 5'd0, 5'd2, 16'h8);
        imem[2] = enc_i(6'h23, 5'd0, 5'd7, 16'h8);
        imem[3] = enc_i(6'h2B, 5'd0, 5'd7, 16'hC);
        push(32'h8, v);
        push(32'hC, v);
        do_reset();
        run_to_halt(1000, cyc);
        check("t4_dmem_accesses", d_count, 4);
        check("t4_halt_pc", pc_out_o, 32'h10);
        check("t4_sb_left", sbq.size(), 0);

        // Test 5: blezal taken on negative, not taken on positive; nandi
        clear_mem();
        dmem[8] = 32'hFFFF_FFFC;
        dmem[9] = 32'h1;
        dmem[10] = 32'h0000_F0F0;
        imem[0] = enc_i(6'h23, 5'd0, 5'd1, 16'h20);
        imem[1] = enc_i(6'h1D, 5'd1, 5'd0, 16'd2);
        imem[4] = enc_i(6'h2B, 5'd0, 5'd31, 16'h0);
        imem[5] = enc_i(6'h23, 5'd0, 5'd1, 16'h24);
        imem[6] = enc_i(6'h1D, 5'd1, 5'd0, 16'd2);
        imem[7] = enc_i(6'h2B, 5'd0, 5'd31, 16'h4);
        imem[8] = enc_i(6'h23, 5'd0, 5'd1, 16'h28);
        imem[9] = enc_i(6'h1C, 5'd1, 5'd4, 16'hFFFF);
        imem[10] = enc_i(6'h2B, 5'd0, 5'd4, 16'h8);
        push(32'h0, 32'h8);
        push(32'h4, 32'h8);
        push(32'h8, 32'hFFFF_0F0F);
        do_reset();
        run_to_halt(1500, cyc);
        check("t5_status_untouched", 32'(status_out_o), 0);
        check("t5_halt_pc", pc_out_o, 32'h2C);
        check("t5_sb_left", sbq.size(), 0);

        // Test 6: jmxor, addi into r0, undefined opcode halts with no further requests
        clear_mem();
        dmem[8] = 32'hF;
        dmem[9] = 32'h3;
        dmem[3] = 32'h4;
        imem[0] = enc_i(6'h23, 5'd0, 5'd8, 16'h20);
        imem[1] = enc_i(6'h23, 5'd0, 5'd9, 16'h24);
        imem[2] = enc_i(6'h1F, 5'd8, 5'd9, 16'h0);
        imem[4] = enc_i(6'h08, 5'd0, 5'd0, 16'd5);
        imem[5] = enc_i(6'h2B, 5'd0, 5'd31, 16'h0);
        imem[6] = enc_i(6'h2B, 5'd0, 5'd0, 16'h4);
        imem[7] = HALT_W;
        imem[8] = enc_i(6'h2B, 5'd0, 5'd0, 16'h8);
        push(32'h0, 32'hC);
        push(32'h4, 32'h0);
        do_reset();
        run_to_halt(1500, cyc);
        check("t6_halt_pc", pc_out_o, 32'h1C);
        reqs = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (imem_req_o || dmem_req_o) reqs++;
        end
        check("t6_no_req_after_halt", reqs, 0);
        check("t6_still_halted", halted_o, 1);
        check("t6_sb_left", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
